fetch: RTL
==========

# fetch

Instruction fetch stage, directly upstream of the decoder. Drives the synchronous instruction memory address and presents each returned instruction to the decoder together with its address (`NPC_out`) and a 4-bit path tag. Control inputs:
- `hazard` from the decoder (active-low stall).
- `jump` / `jump_target` from execute (redirect).

Squashes the wrong-path word after every redirect and increments the tag so downstream stages can discard stale instructions.

## Interface
Parameters:
- `START_ADDR`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: clock
- `reset`  in  1: reset, asynchronous, active-low
- `hazard`  in  1: from decoder; 0 = stall, hold current instruction and NPC
- `jump`  in  1: redirect request from execute, one-cycle pulse
- `jump_target`  in  32: redirect address; bits [1:0] are ignored and treated as 00
- `instruction_addr`  out  32: address to instruction memory; registered PC
- `instruction_data`  in  32: memory read data, valid the cycle after the address
- `instruction_out`  out  32: instruction to decoder `instruction_in`
- `NPC_out`  out  32: address of `instruction_out`
- `tag_out`  out  4: current path tag

## Operation
- Internal state:
  - `PC` (drives `instruction_addr`)
  - `NPC_out` register
  - `tag_out` register
  - `hold` register (32)
  - `state` ∈ {BOOT, RUN, REDIRECT}
- Reset (asynchronous, any time):
  - `PC` = `NPC_out` = START_ADDR; `tag_out` = 0
  - `hold` = 32'h00000013; `state` = BOOT
- `instruction_out` (combinational):
  - BOOT, REDIRECT: 32'h00000013 (NOP)
  - RUN with stalled_r = 1: `hold`
  - RUN with stalled_r = 0: `instruction_data`
- stalled_r = registered `!hazard`, qualified by `state == RUN` (0 in BOOT/REDIRECT). Reset value 0.
- `hold` <= `instruction_out` every cycle in which `hazard` = 0.
- Update priority per cycle: `jump` > stall > advance.
  - `jump`=1 (any state): `PC` <= {`jump_target`[31:2], 2'b00}; `NPC_out` <= same; `tag_out` <= `tag_out` + 1 (mod 16, 15→0); `state` <= REDIRECT.
  - `jump`=0, state RUN, `hazard`=0: `PC`, `NPC_out`, `tag_out` hold; `state` stays RUN.
  - `jump`=0, state RUN, `hazard`=1: `NPC_out` <= `PC`; `PC` <= `PC` + 4 (mod 2^32).
  - `jump`=0, state BOOT or REDIRECT: advance as above regardless of `hazard` (NOP carries no operands); `state` <= RUN.
- State transitions:
  - BOOT→RUN
  - BOOT→REDIRECT on `jump`
  - RUN→REDIRECT on `jump`
  - REDIRECT→RUN
  - REDIRECT→REDIRECT on a back-to-back `jump`
- Memory word arriving in REDIRECT belongs to the old path and is never output.

## Timing
- Fetch latency: address presented in cycle n, instruction on `instruction_out` in cycle n+1 (RUN).
- After reset release:
  - cycle 0: BOOT, outputs NOP with NPC_out = START_ADDR
  - cycle 1: I(START_ADDR) with NPC_out = START_ADDR
- Redirect penalty: `jump` in cycle k →
  - cycle k+1: NOP, NPC_out = target, tag_out = old+1
  - cycle k+2: I(target)
- Instruction and NPC presented in cycle k are still output during k. Execute discards them by tag.
- Stall: `hazard`=0 in cycle k → cycle k+1 presents the identical instruction/NPC (from `hold`). The first cycle with `hazard`=1 releases it. The next instruction follows one cycle later with no bubble.
- `instruction_addr`, `NPC_out` and `tag_out` are glitch-free register outputs.

## Test plan
- Reset release, memory returns word = address, START_ADDR = 0x100, `hazard` = 1 → out: NOP, 0x100, 0x104, 0x108; NPC_out: 0x100, 0x100, 0x104, 0x108; tag 0.
- Stall: `hazard` low 2 cycles while 0x108 is output → 0x108 output 3 cycles with NPC_out = 0x108, `instruction_addr` held at 0x10C, then 0x10C follows with no gap.
- Jump: `jump`=1, target 0x203 while 0x10C is output → next cycle NOP, NPC_out = 0x200, tag 1, `instruction_addr` = 0x200; then 0x200, 0x204.
- Jump with `hazard`=0 in the same cycle → jump wins: REDIRECT, tag increments, `PC` = target.
- Back-to-back jumps to 0x300 then 0x400 → two NOP cycles, tag +2, then 0x400. Seventeen jumps from tag 0 → tag_out = 1 (wrap verified).
- Async reset asserted mid-stall → outputs immediately: NOP, PC = NPC_out = START_ADDR, tag 0. Restart matches the first scenario.

Source files
------------

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Brief    : Instruction fetch stage. Drives the synchronous instruction
//            memory address, presents each returned word to the decoder with
//            its address and a 4-bit path tag, stalls on decoder hazard and
//            squashes the wrong-path word after every redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instruction_addr,
  input  logic [31:0] instruction_data,
  output logic [31:0] instruction_out,
  output logic [31:0] NPC_out,
  output logic [3:0]  tag_out
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_npc;
  logic [31:0] w_npc_next;
  logic [3:0]  r_tag;
  logic [3:0]  w_tag_next;
  logic [31:0] r_hold;
  logic        r_stalled;
  logic [31:0] w_jump_addr;
  logic        w_unused_bits;

  // Redirect targets are word aligned; the low two bits carry no meaning.
  assign w_jump_addr   = {jump_target[31:2], 2'b00};
  assign w_unused_bits = ^jump_target[1:0];

  // Next-state logic: jump beats stall beats advance. BOOT/REDIRECT always
  // advance because the NOP they present cannot be the cause of a hazard.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_npc_next   = r_npc;
    w_tag_next   = r_tag;
    if (jump) begin
      w_state_next = REDIRECT;
      w_pc_next    = w_jump_addr;
      w_npc_next   = w_jump_addr;
      w_tag_next   = r_tag + 4'd1;
    end else if ((r_state == RUN) && !hazard) begin
      w_state_next = RUN;
    end else begin
      w_state_next = RUN;
      w_npc_next   = r_pc;
      w_pc_next    = r_pc + 32'd4;
    end
  end

  // Word to decoder: NOP while the memory word is stale (boot or old path),
  // the held copy while stalled, otherwise the fresh memory word.
  always_comb begin
    instruction_out = C_NOP;
    if (r_state == RUN) begin
      instruction_out = r_stalled ? r_hold : instruction_data;
    end
  end

  // Fetch state registers: FSM, PC, presented address and path tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= START_ADDR;
      r_npc   <= START_ADDR;
      r_tag   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_npc   <= w_npc_next;
      r_tag   <= w_tag_next;
    end
  end

  // Capture the presented word whenever the decoder stalls, and remember
  // that the next RUN cycle must replay it instead of the memory output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold    <= C_NOP;
      r_stalled <= 1'b0;
    end else begin
      if (!hazard) begin
        r_hold <= instruction_out;
      end
      r_stalled <= (r_state == RUN) && !hazard;
    end
  end

  assign instruction_addr = r_pc;
  assign NPC_out          = r_npc;
  assign tag_out          = r_tag;

endmodule
`default_nettype wire
